// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: ALU/NIC writeback sources, decode hazard checks and register-file write port
interface wb_arbiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 4
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    logic                  alu_wb_valid;
    logic [ADDR_WIDTH-1:0] alu_wb_addr;
    logic [DATA_WIDTH-1:0] alu_wb_data;
    logic [2:0]            alu_wb_sel;
    logic                  nic_ld_valid;
    logic                  nic_ld_ready;
    logic [ADDR_WIDTH-1:0] nic_ld_addr;
    logic [DATA_WIDTH-1:0] nic_ld_data;
    logic [2:0]            nic_ld_sel;
    logic [ADDR_WIDTH-1:0] chk_addr_0;
    logic [ADDR_WIDTH-1:0] chk_addr_1;
    logic                  hazard_0;
    logic                  hazard_1;
    logic [CW-1:0]         fifo_count;
    logic                  rf_we;
    logic [ADDR_WIDTH-1:0] rf_addr_wr;
    logic [DATA_WIDTH-1:0] rf_data_in;
    logic [2:0]            rf_sel;
    modport master (
        output alu_wb_valid, alu_wb_addr, alu_wb_data, alu_wb_sel,
        output nic_ld_valid, nic_ld_addr, nic_ld_data, nic_ld_sel,
        output chk_addr_0, chk_addr_1,
        input  nic_ld_ready, hazard_0, hazard_1, fifo_count,
        input  rf_we, rf_addr_wr, rf_data_in, rf_sel
    );
    modport slave (
        input  alu_wb_valid, alu_wb_addr, alu_wb_data, alu_wb_sel,
        input  nic_ld_valid, nic_ld_addr, nic_ld_data, nic_ld_sel,
        input  chk_addr_0, chk_addr_1,
        output nic_ld_ready, hazard_0, hazard_1, fifo_count,
        output rf_we, rf_addr_wr, rf_data_in, rf_sel
    );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: ALU writeback wins the register-file port; NIC load returns are buffered and drained in idle slots
module wb_arbiter #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 4
) (
    input logic clk,
    input logic reset,
    wb_arbiter_if.slave bus
);
    localparam int PW = $clog2(FIFO_DEPTH);
    logic [ADDR_WIDTH-1:0] q_addr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] q_data [FIFO_DEPTH];
    logic [2:0]            q_sel  [FIFO_DEPTH];
    logic [PW-1:0]         rd_ptr, wr_ptr;
    logic [PW:0]           count;
    logic                  alu_go, nic_ok, pop, byp, push, hz0, hz1;
    assign bus.nic_ld_ready = reset && count < (PW+1)'(FIFO_DEPTH);
    assign alu_go = bus.alu_wb_valid && bus.alu_wb_addr != '0;
    assign nic_ok = bus.nic_ld_valid && bus.nic_ld_ready && bus.nic_ld_addr != '0;
    assign pop = !alu_go && count != '0;
    assign byp = !alu_go && count == '0 && nic_ok;
    assign push = nic_ok && !byp;
    assign bus.fifo_count = count;
    assign bus.hazard_0 = hz0 && bus.chk_addr_0 != '0;
    assign bus.hazard_1 = hz1 && bus.chk_addr_1 != '0;
    // an entry is occupied when its distance from the read pointer is below the count
    always_comb begin
        hz0 = 1'b0;
        hz1 = 1'b0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if ({1'b0, PW'(i) - rd_ptr} < count) begin
                hz0 = hz0 || q_addr[i] == bus.chk_addr_0;
                hz1 = hz1 || q_addr[i] == bus.chk_addr_1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            bus.rf_we      <= 1'b0;
            bus.rf_addr_wr <= '0;
            bus.rf_data_in <= '0;
            bus.rf_sel     <= '0;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
        end else begin
            bus.rf_we      <= alu_go || pop || byp;
            bus.rf_addr_wr <= alu_go ? bus.alu_wb_addr : pop ? q_addr[rd_ptr] : byp ? bus.nic_ld_addr : bus.rf_addr_wr;
            bus.rf_data_in <= alu_go ? bus.alu_wb_data : pop ? q_data[rd_ptr] : byp ? bus.nic_ld_data : bus.rf_data_in;
            bus.rf_sel     <= alu_go ? bus.alu_wb_sel : pop ? q_sel[rd_ptr] : byp ? bus.nic_ld_sel : bus.rf_sel;
            if (push) begin
                q_addr[wr_ptr] <= bus.nic_ld_addr;
                q_data[wr_ptr] <= bus.nic_ld_data;
                q_sel[wr_ptr]  <= bus.nic_ld_sel;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (PW+1)'(push) - (PW+1)'(pop);
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed table, corner sequences and random traffic against a queue-based reference model
module tb_wb_arbiter;
    localparam int DW = 64;
    localparam int AW = 5;
    localparam int FD = 4;
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [2:0]    sel;
    } ent_t;
    typedef struct packed {
        logic          av;
        logic [AW-1:0] aa;
        logic          nv;
        logic [AW-1:0] na;
        logic          rdy;
        logic          we;
        logic [AW-1:0] addr;
        logic [2:0]    cnt;
    } vec_t;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    wb_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) bus ();
    wb_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );
    ent_t          m_q[$];
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic [2:0]    m_sel;
    int checks = 0;
    int errors = 0;
    vec_t tbl[12];
    bit hold;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit hz(logic [AW-1:0] a);
        foreach (m_q[i]) if (a != 0 && m_q[i].addr == a) return 1'b1;
        return 1'b0;
    endfunction

    task automatic drive(bit av, logic [AW-1:0] aa, bit nv, logic [AW-1:0] na);
        bus.alu_wb_valid = av;
        bus.alu_wb_addr  = aa;
        bus.alu_wb_data  = {48'hC0DE_0000_0000, 11'h0, aa};
        bus.alu_wb_sel   = 3'd0;
        bus.nic_ld_valid = nv;
        bus.nic_ld_addr  = na;
        bus.nic_ld_data  = {48'hA5A5_0000_0000, 11'h0, na};
        bus.nic_ld_sel   = 3'd1;
    endtask

    // Check combinational outputs, then advance the model by the upcoming edge.
    task automatic pre();
        bit rdy, go, acc, byp;
        ent_t n, e;
        #1;
        rdy = reset && m_q.size() < FD;
        chk("nic_ld_ready", 64'(bus.nic_ld_ready), 64'(rdy));
        chk("fifo_count", 64'(bus.fifo_count), 64'(m_q.size()));
        chk("hazard_0", 64'(bus.hazard_0), 64'(hz(bus.chk_addr_0)));
        chk("hazard_1", 64'(bus.hazard_1), 64'(hz(bus.chk_addr_1)));
        go  = bus.alu_wb_valid && bus.alu_wb_addr != 0;
        acc = bus.nic_ld_valid && rdy && bus.nic_ld_addr != 0;
        n   = '{bus.nic_ld_addr, bus.nic_ld_data, bus.nic_ld_sel};
        if (!reset) begin
            m_q.delete();
            m_we = 0; m_addr = 0; m_data = 0; m_sel = 0;
        end else begin
            byp  = !go && m_q.size() == 0 && acc;
            m_we = go || m_q.size() != 0 || acc;
            if (go) begin
                m_addr = bus.alu_wb_addr; m_data = bus.alu_wb_data; m_sel = bus.alu_wb_sel;
            end else if (m_q.size() != 0) begin
                e = m_q.pop_front();
                m_addr = e.addr; m_data = e.data; m_sel = e.sel;
            end else if (acc) begin
                m_addr = n.addr; m_data = n.data; m_sel = n.sel;
            end
            if (acc && !byp) m_q.push_back(n);
        end
    endtask

    task automatic post();
        @(posedge clk);
        #1;
        chk("rf_we", 64'(bus.rf_we), 64'(m_we));
        chk("rf_addr_wr", 64'(bus.rf_addr_wr), 64'(m_addr));
        chk("rf_data_in", bus.rf_data_in, m_data);
        chk("rf_sel", 64'(bus.rf_sel), 64'(m_sel));
    endtask

    initial begin
        tbl = '{
            '{1, 3, 1, 7,  1, 1, 3,  1},
            '{1, 3, 1, 8,  1, 1, 3,  2},
            '{1, 3, 1, 9,  1, 1, 3,  3},
            '{1, 3, 1, 10, 1, 1, 3,  4},
            '{1, 3, 1, 11, 0, 1, 3,  4},
            '{1, 3, 1, 11, 0, 1, 3,  4},
            '{0, 0, 1, 11, 0, 1, 7,  3},
            '{0, 0, 1, 11, 1, 1, 8,  3},
            '{0, 0, 0, 0,  1, 1, 9,  2},
            '{0, 0, 0, 0,  1, 1, 10, 1},
            '{0, 0, 0, 0,  1, 1, 11, 0},
            '{0, 0, 0, 0,  1, 0, 11, 0}
        };
        bus.chk_addr_0 = 0;
        bus.chk_addr_1 = 0;
        drive(0, 0, 1, 5);
        reset = 0;
        m_we = 0; m_addr = 0; m_data = 0; m_sel = 0;
        @(posedge clk);
        #1;
        repeat (2) begin
            pre();
            chk("rst_ready", 64'(bus.nic_ld_ready), 64'(0));
            post();
            chk("rst_we", 64'(bus.rf_we), 64'(0));
            chk("rst_count", 64'(bus.fifo_count), 64'(0));
        end
        reset = 1;
        drive(0, 0, 0, 0);
        pre();
        chk("ready_after_rst", 64'(bus.nic_ld_ready), 64'(1));
        post();
        drive(0, 0, 1, 5);
        bus.nic_ld_data = 64'h1122334455667788;
        bus.nic_ld_sel  = 3'd0;
        pre();
        post();
        chk("byp_we", 64'(bus.rf_we), 64'(1));
        chk("byp_addr", 64'(bus.rf_addr_wr), 64'(5));
        chk("byp_data", bus.rf_data_in, 64'h1122334455667788);
        chk("byp_count", 64'(bus.fifo_count), 64'(0));
        drive(0, 0, 0, 0);
        pre();
        post();
        foreach (tbl[i]) begin
            drive(tbl[i].av, tbl[i].aa, tbl[i].nv, tbl[i].na);
            pre();
            chk("tbl_ready", 64'(bus.nic_ld_ready), 64'(tbl[i].rdy));
            post();
            chk("tbl_we", 64'(bus.rf_we), 64'(tbl[i].we));
            chk("tbl_addr", 64'(bus.rf_addr_wr), 64'(tbl[i].addr));
            chk("tbl_count", 64'(bus.fifo_count), 64'(tbl[i].cnt));
        end
        bus.chk_addr_0 = 12;
        bus.chk_addr_1 = 0;
        drive(1, 3, 1, 12);
        pre();
        post();
        drive(1, 3, 0, 0);
        pre();
        chk("hz_buffered", 64'(bus.hazard_0), 64'(1));
        chk("hz1_zero", 64'(bus.hazard_1), 64'(0));
        post();
        drive(0, 0, 0, 0);
        pre();
        chk("hz_pop_cycle", 64'(bus.hazard_0), 64'(1));
        post();
        chk("hz_pop_addr", 64'(bus.rf_addr_wr), 64'(12));
        pre();
        chk("hz_cleared", 64'(bus.hazard_0), 64'(0));
        post();
        drive(1, 3, 1, 13);
        pre();
        post();
        drive(1, 0, 1, 0);
        pre();
        post();
        chk("a0_head_we", 64'(bus.rf_we), 64'(1));
        chk("a0_head_addr", 64'(bus.rf_addr_wr), 64'(13));
        chk("a0_count", 64'(bus.fifo_count), 64'(0));
        drive(0, 0, 1, 0);
        pre();
        chk("nic0_ready", 64'(bus.nic_ld_ready), 64'(1));
        post();
        chk("nic0_we", 64'(bus.rf_we), 64'(0));
        chk("nic0_count", 64'(bus.fifo_count), 64'(0));
        bus.chk_addr_0 = 20;
        for (int i = 0; i < 3; i++) begin
            drive(1, 3, 1, 5'(20 + i));
            pre();
            post();
        end
        chk("drain_count", 64'(bus.fifo_count), 64'(3));
        drive(0, 0, 0, 0);
        reset = 0;
        pre();
        post();
        chk("mid_rst_count", 64'(bus.fifo_count), 64'(0));
        chk("mid_rst_we", 64'(bus.rf_we), 64'(0));
        chk("mid_rst_hz", 64'(bus.hazard_0), 64'(0));
        reset = 1;
        repeat (3) begin
            pre();
            post();
            chk("no_stale", 64'(bus.rf_we), 64'(0));
        end
        hold = 0;
        repeat (600) begin
            bus.alu_wb_valid = $urandom_range(0, 9) < 6;
            bus.alu_wb_addr  = 5'($urandom_range(0, 31));
            bus.alu_wb_data  = {$urandom, $urandom};
            bus.alu_wb_sel   = 3'($urandom_range(0, 7));
            if (!hold) begin
                bus.nic_ld_valid = $urandom_range(0, 9) < 6;
                bus.nic_ld_addr  = 5'($urandom_range(0, 15));
                bus.nic_ld_data  = {$urandom, $urandom};
                bus.nic_ld_sel   = 3'($urandom_range(0, 7));
            end
            bus.chk_addr_0 = 5'($urandom_range(0, 15));
            bus.chk_addr_1 = 5'($urandom_range(0, 15));
            reset = $urandom_range(0, 99) != 0;
            pre();
            hold = bus.nic_ld_valid && !bus.nic_ld_ready;
            post();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
